// File: rtl/poly_mult_tile_scheduler_if.sv
// Bundle of the scheduler's memory-read, multiplier-handshake and status signals.
// master: the scheduler side; slave: the memories / multiplier / control side.
interface poly_mult_tile_scheduler_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int POLY_A_WIDTH      = 64,
  parameter int POLY_B_WIDTH      = 64,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8
);
  localparam int NA  = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
  localparam int NB  = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
  localparam int AW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int OW  = $clog2(POLY_A_WIDTH + POLY_B_WIDTH);
  localparam int TAW = POLY_A_TILE_WIDTH * DATA_WIDTH;
  localparam int TBW = POLY_B_TILE_WIDTH * DATA_WIDTH;

  logic           start;
  logic           a_rd_en;
  logic [AW-1:0]  a_rd_addr;
  logic [TAW-1:0] a_rd_data;
  logic           b_rd_en;
  logic [BW-1:0]  b_rd_addr;
  logic [TBW-1:0] b_rd_data;
  logic [TAW-1:0] tile_a;
  logic [TBW-1:0] tile_b;
  logic           mult_inputs_ready;
  logic           mult_outputs_ready;
  logic           result_valid;
  logic [OW-1:0]  result_offset;
  logic           busy;
  logic           done;

  modport master (
    input  start, a_rd_data, b_rd_data, mult_outputs_ready,
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, tile_a, tile_b,
    output mult_inputs_ready, result_valid, result_offset, busy, done
  );

  modport slave (
    output start, a_rd_data, b_rd_data, mult_outputs_ready,
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, tile_a, tile_b,
    input  mult_inputs_ready, result_valid, result_offset, busy, done
  );
endinterface

// File: rtl/poly_mult_tile_scheduler.sv
// Walks every (A-tile, B-tile) pair in raster order (B inner), fetches both tiles,
// issues them to the multiplier and tags each accepted result with its output offset.
module poly_mult_tile_scheduler #(
  parameter int DATA_WIDTH        = 64,
  parameter int POLY_A_WIDTH      = 64,
  parameter int POLY_B_WIDTH      = 64,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  poly_mult_tile_scheduler_if.master bus
);
  localparam int NA  = POLY_A_WIDTH / POLY_A_TILE_WIDTH;
  localparam int NB  = POLY_B_WIDTH / POLY_B_TILE_WIDTH;
  localparam int AW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int OW  = $clog2(POLY_A_WIDTH + POLY_B_WIDTH);
  localparam int TAW = POLY_A_TILE_WIDTH * DATA_WIDTH;
  localparam int TBW = POLY_B_TILE_WIDTH * DATA_WIDTH;

  localparam logic [AW-1:0] ALast  = AW'(NA - 1);
  localparam logic [BW-1:0] BLast  = BW'(NB - 1);
  localparam logic [OW-1:0] ATileW = OW'(POLY_A_TILE_WIDTH);
  localparam logic [OW-1:0] BTileW = OW'(POLY_B_TILE_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRd,
    StIssue,
    StWaitMult,
    StFinish
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  a_idx_q, a_idx_d;
  logic [BW-1:0]  b_idx_q, b_idx_d;
  logic [TAW-1:0] tile_a_q;
  logic [TBW-1:0] tile_b_q;
  logic           rd_en_q;
  logic           issue_q;
  logic           busy_q;
  logic           done_q;
  logic           result_valid;

  // Next-state, index advance and the accept pulse.
  always_comb begin
    state_d      = state_q;
    a_idx_d      = a_idx_q;
    b_idx_d      = b_idx_q;
    result_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_idx_d = '0;
          b_idx_d = '0;
          state_d = StFetch;
        end
      end
      StFetch:  state_d = StWaitRd;
      StWaitRd: state_d = StIssue;
      StIssue:  state_d = StWaitMult;
      StWaitMult: begin
        if (bus.mult_outputs_ready) begin
          result_valid = 1'b1;
          if ((a_idx_q == ALast) && (b_idx_q == BLast)) begin
            state_d = StFinish;
          end else begin
            state_d = StFetch;
            if (b_idx_q == BLast) begin
              b_idx_d = '0;
              a_idx_d = a_idx_q + AW'(1);
            end else begin
              b_idx_d = b_idx_q + BW'(1);
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, indices and registered strobes; strobes are decoded from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_idx_q <= '0;
      b_idx_q <= '0;
      rd_en_q <= 1'b0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_idx_q <= a_idx_d;
      b_idx_q <= b_idx_d;
      rd_en_q <= (state_d == StFetch);
      issue_q <= (state_d == StIssue);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFinish);
    end
  end

  // Tile capture one cycle after the read strobe; held until the next fetch completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_a_q <= '0;
      tile_b_q <= '0;
    end else if (state_q == StWaitRd) begin
      tile_a_q <= bus.a_rd_data;
      tile_b_q <= bus.b_rd_data;
    end
  end

  assign bus.a_rd_en           = rd_en_q;
  assign bus.b_rd_en           = rd_en_q;
  assign bus.a_rd_addr         = a_idx_q;
  assign bus.b_rd_addr         = b_idx_q;
  assign bus.tile_a            = tile_a_q;
  assign bus.tile_b            = tile_b_q;
  assign bus.mult_inputs_ready = issue_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.result_valid      = result_valid;
  // Widened before multiplying so the largest offset is never truncated.
  assign bus.result_offset     = (OW'(a_idx_q) * ATileW) + (OW'(b_idx_q) * BTileW);

endmodule

// File: tb/tb_poly_mult_tile_scheduler.sv
// Randomized self-checking bench: a transaction-level timing model predicts every
// output each cycle; literal run lengths and offsets pin the model itself.
module tb_poly_mult_tile_scheduler;
  localparam int DW    = 64;
  localparam int PAW   = 64;
  localparam int PBW   = 64;
  localparam int PATW  = 8;
  localparam int PBTW  = 8;
  localparam int NA    = PAW / PATW;
  localparam int NB    = PBW / PBTW;
  localparam int NPAIR = NA * NB;
  localparam int OW    = $clog2(PAW + PBW);
  localparam int TAW   = PATW * DW;
  localparam int TBW   = PBTW * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  poly_mult_tile_scheduler_if #(
    .DATA_WIDTH(DW), .POLY_A_WIDTH(PAW), .POLY_B_WIDTH(PBW),
    .POLY_A_TILE_WIDTH(PATW), .POLY_B_TILE_WIDTH(PBTW)
  ) bus ();

  poly_mult_tile_scheduler #(
    .DATA_WIDTH(DW), .POLY_A_WIDTH(PAW), .POLY_B_WIDTH(PBW),
    .POLY_A_TILE_WIDTH(PATW), .POLY_B_TILE_WIDTH(PBTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Coefficient memories: one-cycle read latency, garbage when not read.
  logic [TAW-1:0] mem_a [NA];
  logic [TBW-1:0] mem_b [NB];
  logic           rd_pend;
  int             rd_a, rd_b;

  function automatic logic [511:0] rnd_wide();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  always @(negedge clk) begin
    rd_pend = bus.a_rd_en;
    rd_a    = int'(bus.a_rd_addr);
    rd_b    = int'(bus.b_rd_addr);
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      bus.a_rd_data = mem_a[rd_a];
      bus.b_rd_data = mem_b[rd_b];
    end else begin
      bus.a_rd_data = TAW'(rnd_wide());
      bus.b_rd_data = TBW'(rnd_wide());
    end
  end

  // Multiplier: 0 = ready exactly mdelay cycles after issue, 1 = always high,
  // 2 = random level every cycle.
  int mmode      = 2;
  int mdelay     = 2;
  int last_issue = -1000;

  always @(posedge clk) begin
    #1;
    if (bus.mult_inputs_ready) last_issue = cyc;
    case (mmode)
      0:       bus.mult_outputs_ready = (cyc == last_issue + mdelay);
      1:       bus.mult_outputs_ready = 1'b1;
      default: bus.mult_outputs_ready = ($urandom_range(0, 3) == 0);
    endcase
  end

  // Reference model: pair k is fetched 1 cycle after the previous accept (or start),
  // issued 3 cycles after it, and accepted on the first later cycle with ready high.
  bit            running  = 0;
  int            k        = 0;
  int            base     = 0;
  int            done_cyc = -10;
  int            run_start_cyc, run_done_cyc;
  int            run_issues, run_results;
  int            dones = 0;
  logic [OW-1:0] offs [NPAIR];
  bit            ef, ei, ew, erv, ed, idle_now;
  int            ka, kb;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_a_rd_en", bus.a_rd_en, 0);
      chk("rst_b_rd_en", bus.b_rd_en, 0);
      chk("rst_issue", bus.mult_inputs_ready, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_tile_a", bus.tile_a, 0);
      chk("rst_tile_b", bus.tile_b, 0);
      chk("rst_a_rd_addr", bus.a_rd_addr, 0);
      chk("rst_b_rd_addr", bus.b_rd_addr, 0);
      chk("rst_offset", bus.result_offset, 0);
      running  = 0;
      done_cyc = -10;
    end else begin
      ka       = k / NB;
      kb       = k % NB;
      ef       = running && (cyc == base + 1);
      ei       = running && (cyc == base + 3);
      ew       = running && (cyc > base + 3);
      erv      = ew && bus.mult_outputs_ready;
      ed       = (cyc == done_cyc);
      idle_now = !running && !ed;
      chk("busy", bus.busy, running || ed);
      chk("done", bus.done, ed);
      chk("a_rd_en", bus.a_rd_en, ef);
      chk("b_rd_en", bus.b_rd_en, ef);
      chk("mult_inputs_ready", bus.mult_inputs_ready, ei);
      chk("result_valid", bus.result_valid, erv);
      if (ef) begin
        chk("a_rd_addr", bus.a_rd_addr, ka);
        chk("b_rd_addr", bus.b_rd_addr, kb);
      end
      if (ei || ew) begin
        chk("tile_a", bus.tile_a, mem_a[ka]);
        chk("tile_b", bus.tile_b, mem_b[kb]);
      end
      if (erv) chk("result_offset", bus.result_offset, ka * PATW + kb * PBTW);
      if (bus.mult_inputs_ready) run_issues++;
      if (bus.result_valid) begin
        if (run_results < NPAIR) offs[run_results] = bus.result_offset;
        run_results++;
      end
      if (bus.done) begin
        dones++;
        run_done_cyc = cyc;
      end
      if (erv) begin
        if (k == NPAIR - 1) begin
          running  = 0;
          done_cyc = cyc + 1;
        end else begin
          k++;
          base = cyc;
        end
      end
      if (idle_now && bus.start) begin
        running       = 1;
        k             = 0;
        base          = cyc;
        run_start_cyc = cyc;
        run_issues    = 0;
        run_results   = 0;
      end
    end
  end

  task automatic fill_mem(input bit by_index);
    for (int i = 0; i < NA; i++) mem_a[i] = by_index ? TAW'(i) : TAW'(rnd_wide());
    for (int i = 0; i < NB; i++) mem_b[i] = by_index ? TBW'(i) : TBW'(rnd_wide());
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int target;
    target = dones + 1;
    for (int i = 0; i < budget && dones < target; i++) @(posedge clk);
    chk({name, "_done_seen"}, dones, target);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int d1;

  initial begin
    bus.start = 1'b0;
    fill_mem(1'b1);

    // Reset held while start and the multiplier handshake toggle.
    mmode = 2;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.start = ~bus.start;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);

    // Full run: tile = index, ready 2 cycles after issue -> 5 cycles per pair.
    mmode  = 0;
    mdelay = 2;
    pulse_start();
    wait_done("default", 2000);
    chk("default_duration", run_done_cyc - run_start_cyc, 321);
    chk("default_issues", run_issues, 64);
    chk("default_results", run_results, 64);
    chk("offset_first", offs[0], 0);
    chk("offset_0_7", offs[7], 56);
    chk("offset_1_0", offs[8], 8);
    chk("offset_last", offs[63], 112);
    repeat (3) @(posedge clk);

    // Long multiplier latency with a start pulse during pair 5's wait.
    fill_mem(1'b0);
    mdelay = 20;
    pulse_start();
    for (int i = 0; i < 1000 && run_issues < 6; i++) @(posedge clk);
    chk("reach_pair5", run_issues, 6);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("slow", 3000);
    chk("slow_duration", run_done_cyc - run_start_cyc, 1473);
    chk("slow_issues", run_issues, 64);
    repeat (5) @(posedge clk);
    chk("slow_single_done", bus.busy, 0);

    // Ready held high: 4 cycles per pair.
    fill_mem(1'b0);
    mmode = 1;
    pulse_start();
    wait_done("const", 1000);
    chk("const_duration", run_done_cyc - run_start_cyc, 257);
    chk("const_results", run_results, 64);
    repeat (3) @(posedge clk);

    // Random handshake, start held through FINISH for a back-to-back run.
    fill_mem(1'b0);
    mmode = 2;
    @(posedge clk); #1;
    bus.start = 1'b1;
    wait_done("rand1", 3000);
    d1 = run_done_cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_restart", run_start_cyc, d1 + 1);
    wait_done("rand2", 3000);
    chk("rand2_issues", run_issues, 64);
    chk("rand2_results", run_results, 64);
    repeat (3) @(posedge clk);

    // Asynchronous reset during pair (3,4), then a clean restart.
    mmode  = 0;
    mdelay = 2;
    pulse_start();
    for (int i = 0; i < 1000 && run_issues < 29; i++) @(posedge clk);
    chk("reach_pair_3_4", run_issues, 29);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_tile_a", bus.tile_a, 0);
    chk("async_addr", bus.a_rd_addr, 0);
    chk("async_offset", bus.result_offset, 0);
    d1 = dones;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("no_done_after_abort", dones, d1);
    pulse_start();
    wait_done("restart", 2000);
    chk("restart_issues", run_issues, 64);
    chk("restart_duration", run_done_cyc - run_start_cyc, 321);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
